// File: rtl/no_brdr_out_collector.sv
// Output collector for the no-border filter: clamps each signed result to an
// unsigned pixel, tags it with its position in the reduced output frame and
// buffers it in a first-word-fall-through FIFO behind a valid/ready handshake.
module no_brdr_out_collector #(
  parameter int ROW_WIDTH  = 256,
  parameter int COL_HEIGHT = 256,
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int SLACK      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pix_valid_in,
  input  logic signed [PIX_BIT:0]   pix_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [PIX_BIT-1:0]        out_pix,
  output logic                      out_sol,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic                      almost_full,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_ovf,
  output logic                      err_unexp
);

  localparam int OW    = ROW_WIDTH - MASK_WIDTH + 1;
  localparam int OH    = COL_HEIGHT - MASK_WIDTH + 1;
  localparam int COL_W = (OW > 1) ? $clog2(OW) : 1;
  localparam int ROW_W = (OH > 1) ? $clog2(OH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PIX_BIT + 3;
  localparam int AF_TH = FIFO_DEPTH - SLACK;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t               state_q;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 almost_full_q;
  logic                 frame_done_q;
  logic                 err_ovf_q;
  logic                 err_unexp_q;

  logic [PIX_BIT-1:0]   pix_clamped;
  logic                 tag_sol;
  logic                 tag_eol;
  logic                 tag_eof;
  logic                 in_take;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [ENT_W-1:0]     head;

  // Negative results saturate to zero; the non-negative range already fits.
  function automatic logic [PIX_BIT-1:0] clamp_pix(input logic signed [PIX_BIT:0] v);
    if (v[PIX_BIT]) begin
      return '0;
    end
    return v[PIX_BIT-1:0];
  endfunction

  // Tagging, handshake and push/pop decisions for the current cycle.
  always_comb begin
    pix_clamped = clamp_pix(pix_in);
    tag_sol     = (col_q == '0);
    tag_eol     = (col_q == COL_W'(OW - 1));
    tag_eof     = tag_eol && (row_q == ROW_W'(OH - 1));
    in_take     = (state_q == ACTIVE) && pix_valid_in;
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    head        = mem_q[rd_ptr_q];
    pop         = !fifo_empty && out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    push        = in_take && (!fifo_full || pop);
    drop        = in_take && fifo_full && !pop;
    count_d     = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Frame sequencing and position counters; counters advance on every
  // accepted input, even a dropped one, so tags stay aligned with the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACTIVE;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        ACTIVE: begin
          if (pix_valid_in) begin
            if (tag_eol) begin
              col_q <= '0;
              if (tag_eof) begin
                row_q   <= '0;
                state_q <= DRAIN;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && head[ENT_W-1]) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end else if (fifo_empty) begin
            // The eof entry was lost to overflow; nothing left to wait for.
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy, almost-full flag and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q       <= count_d;
      almost_full_q <= (count_d >= CNT_W'(AF_TH));
      if (drop) begin
        err_ovf_q <= 1'b1;
      end
      if (pix_valid_in && (state_q != ACTIVE)) begin
        err_unexp_q <= 1'b1;
      end
    end
  end

  // FIFO storage; data only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tag_eof, tag_eol, tag_sol, pix_clamped};
    end
  end

  assign out_valid   = !fifo_empty;
  assign out_pix     = out_valid ? head[PIX_BIT-1:0] : '0;
  assign out_sol     = out_valid & head[PIX_BIT];
  assign out_eol     = out_valid & head[PIX_BIT+1];
  assign out_eof     = out_valid & head[PIX_BIT+2];
  assign almost_full = almost_full_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign err_ovf     = err_ovf_q;
  assign err_unexp   = err_unexp_q;

endmodule

// File: tb/tb_no_brdr_out_collector.sv
// Bench for no_brdr_out_collector: two instances (3x2 and 5x4 output frames),
// a queue-based reference model compared every cycle, plus literal checks.
module tb_no_brdr_out_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       st_s  [2];
  logic       pv_s  [2];
  logic       rdy_s [2];
  logic [8:0] px_s  [2];
  logic       ov_s  [2];
  logic [7:0] op_s  [2];
  logic       sol_s [2];
  logic       eol_s [2];
  logic       eof_s [2];
  logic       af_s  [2];
  logic       busy_s[2];
  logic       fd_s  [2];
  logic       eo_s  [2];
  logic       eu_s  [2];

  no_brdr_out_collector #(
    .ROW_WIDTH(5), .COL_HEIGHT(4), .PIX_BIT(8), .MASK_WIDTH(3), .FIFO_DEPTH(8), .SLACK(4)
  ) u_small (
    .clk(clk), .reset(reset), .start(st_s[0]), .pix_valid_in(pv_s[0]), .pix_in(px_s[0]),
    .out_ready(rdy_s[0]), .out_valid(ov_s[0]), .out_pix(op_s[0]), .out_sol(sol_s[0]),
    .out_eol(eol_s[0]), .out_eof(eof_s[0]), .almost_full(af_s[0]), .busy(busy_s[0]),
    .frame_done(fd_s[0]), .err_ovf(eo_s[0]), .err_unexp(eu_s[0])
  );

  no_brdr_out_collector #(
    .ROW_WIDTH(7), .COL_HEIGHT(6), .PIX_BIT(8), .MASK_WIDTH(3), .FIFO_DEPTH(8), .SLACK(4)
  ) u_big (
    .clk(clk), .reset(reset), .start(st_s[1]), .pix_valid_in(pv_s[1]), .pix_in(px_s[1]),
    .out_ready(rdy_s[1]), .out_valid(ov_s[1]), .out_pix(op_s[1]), .out_sol(sol_s[1]),
    .out_eol(eol_s[1]), .out_eof(eof_s[1]), .almost_full(af_s[1]), .busy(busy_s[1]),
    .frame_done(fd_s[1]), .err_ovf(eo_s[1]), .err_unexp(eu_s[1])
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         ow  [2] = '{3, 5};
  int         nfr [2] = '{6, 20};
  int         m_state[2];   // 0 idle, 1 collecting, 2 draining
  int         m_k[2];       // index of next pixel within the frame
  bit         m_ovf[2];
  bit         m_unexp[2];
  bit         m_fd[2];
  logic [10:0] m_q0[$];
  logic [10:0] m_q1[$];

  function automatic int qsz(input int i);
    return (i == 0) ? m_q0.size() : m_q1.size();
  endfunction

  function automatic logic [10:0] qhd(input int i);
    if (qsz(i) == 0) return 11'd0;
    return (i == 0) ? m_q0[0] : m_q1[0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_k[i] = 0; m_ovf[i] = 0; m_unexp[i] = 0; m_fd[i] = 0;
    end
    m_q0.delete();
    m_q1.delete();
  endtask

  task automatic model_step(input int i);
    int          sz;
    bit          pop;
    bit          he;
    logic [10:0] hd;
    logic [10:0] e;
    logic [7:0]  p;
    int          k;
    sz = qsz(i);
    hd = qhd(i);
    pop = (sz > 0) && (rdy_s[i] == 1'b1);
    he = pop && hd[10];
    m_fd[i] = (m_state[i] == 2) && he;
    if (pv_s[i] && m_state[i] != 1) m_unexp[i] = 1;
    if (pop) begin
      if (i == 0) void'(m_q0.pop_front()); else void'(m_q1.pop_front());
    end
    case (m_state[i])
      0: if (st_s[i]) begin m_state[i] = 1; m_k[i] = 0; end
      1: if (pv_s[i]) begin
        p = px_s[i][8] ? 8'd0 : px_s[i][7:0];
        k = m_k[i];
        e = {(k == nfr[i] - 1), (k % ow[i] == ow[i] - 1), (k % ow[i] == 0), p};
        if (sz < 8 || pop) begin
          if (i == 0) m_q0.push_back(e); else m_q1.push_back(e);
        end else begin
          m_ovf[i] = 1;
        end
        m_k[i] = k + 1;
        if (m_k[i] == nfr[i]) m_state[i] = 2;
      end
      default: begin
        if (he) m_state[i] = 0;
        else if (sz == 0) m_state[i] = 0;
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge reset) model_clear();

  // ---------------- per-cycle compare ----------------
  task automatic compare_inst(input int i);
    logic [10:0] hd;
    bit          v;
    hd = qhd(i);
    v  = (qsz(i) != 0);
    chk($sformatf("cmp%0d.out_valid", i), ov_s[i], v);
    if (v) begin
      chk($sformatf("cmp%0d.out_pix", i), op_s[i], hd[7:0]);
      chk($sformatf("cmp%0d.out_sol", i), sol_s[i], hd[8]);
      chk($sformatf("cmp%0d.out_eol", i), eol_s[i], hd[9]);
      chk($sformatf("cmp%0d.out_eof", i), eof_s[i], hd[10]);
    end
    chk($sformatf("cmp%0d.almost_full", i), af_s[i], (qsz(i) >= 4));
    chk($sformatf("cmp%0d.busy", i), busy_s[i], (m_state[i] != 0));
    chk($sformatf("cmp%0d.frame_done", i), fd_s[i], m_fd[i]);
    chk($sformatf("cmp%0d.err_ovf", i), eo_s[i], m_ovf[i]);
    chk($sformatf("cmp%0d.err_unexp", i), eu_s[i], m_unexp[i]);
  endtask

  always @(negedge clk) begin
    compare_inst(0);
    compare_inst(1);
  end

  // ---------------- stimulus helpers ----------------
  logic [10:0] rec0[$];
  logic [10:0] rec1[$];
  int tcnt = 0;
  int lastpop[2];
  int fdtick[2];
  int fdcnt[2];

  task automatic tick();
    logic [10:0] e;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (ov_s[i] === 1'b1 && rdy_s[i] === 1'b1) begin
        e = {eof_s[i], eol_s[i], sol_s[i], op_s[i]};
        if (i == 0) rec0.push_back(e); else rec1.push_back(e);
        lastpop[i] = tcnt;
      end
      if (fd_s[i] === 1'b1) begin
        fdcnt[i]++;
        fdtick[i] = tcnt;
      end
    end
    tcnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic st, input logic v, input logic [8:0] p);
    st_s[i] = st; pv_s[i] = v; px_s[i] = p;
    tick();
    st_s[i] = 1'b0; pv_s[i] = 1'b0;
  endtask

  task automatic wait_fd(input int i, input string nm);
    int c0;
    c0 = fdcnt[i];
    for (int k = 0; k < 40 && fdcnt[i] == c0; k++) tick();
    checks++;
    if (fdcnt[i] == c0) begin
      fails++;
      $display("FAIL %s: frame_done never pulsed within 40 cycles", nm);
    end
  endtask

  task automatic chk_rec(input int i, input int idx, input logic [7:0] pix,
                         input bit sol, input bit eol, input bit eof, input string nm);
    logic [10:0] e;
    int n;
    n = (i == 0) ? rec0.size() : rec1.size();
    checks++;
    if (idx >= n) begin
      fails++;
      $display("FAIL %s: only %0d outputs seen, required entry %0d", nm, n, idx);
    end else begin
      checks--;
      e = (i == 0) ? rec0[idx] : rec1[idx];
      chk({nm, ".pix"}, e[7:0], pix);
      chk({nm, ".sol"}, e[8], sol);
      chk({nm, ".eol"}, e[9], eol);
      chk({nm, ".eof"}, e[10], eof);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    model_clear();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_s[i] = 0; pv_s[i] = 0; px_s[i] = 0; rdy_s[i] = 1;
      lastpop[i] = 0; fdtick[i] = 0; fdcnt[i] = 0;
    end
    @(negedge clk); #1;
    // reset state
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d.out_valid", i), ov_s[i], 0);
      chk($sformatf("rst%0d.out_pix", i), op_s[i], 0);
      chk($sformatf("rst%0d.tags", i), {eof_s[i], eol_s[i], sol_s[i]}, 0);
      chk($sformatf("rst%0d.almost_full", i), af_s[i], 0);
      chk($sformatf("rst%0d.busy", i), busy_s[i], 0);
      chk($sformatf("rst%0d.frame_done", i), fd_s[i], 0);
      chk($sformatf("rst%0d.errs", i), {eo_s[i], eu_s[i]}, 0);
    end
    reset = 1'b1;
    tick();

    // basic 3x2 frame, 10..15
    rec0.delete();
    drive(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) drive(0, 0, 1, 9'(10 + k));
    c0 = fdcnt[0];
    wait_fd(0, "t1.frame_done");
    chk("t1.fd_latency", fdtick[0] - lastpop[0], 1);
    chk("t1.busy_after", busy_s[0], 0);
    tick(); tick();
    chk("t1.fd_count", fdcnt[0] - c0, 1);
    chk("t1.n_out", rec0.size(), 6);
    chk_rec(0, 0, 10, 1, 0, 0, "t1.o0");
    chk_rec(0, 1, 11, 0, 0, 0, "t1.o1");
    chk_rec(0, 2, 12, 0, 1, 0, "t1.o2");
    chk_rec(0, 3, 13, 1, 0, 0, "t1.o3");
    chk_rec(0, 4, 14, 0, 0, 0, "t1.o4");
    chk_rec(0, 5, 15, 0, 1, 1, "t1.o5");

    // clamp
    rec0.delete();
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 9'h1FF);
    drive(0, 0, 1, 9'h100);
    drive(0, 0, 1, 9'h0FF);
    drive(0, 0, 1, 9'h000);
    drive(0, 0, 1, 9'd7);
    drive(0, 0, 1, 9'd8);
    wait_fd(0, "t2.frame_done");
    chk_rec(0, 0, 0, 1, 0, 0, "t2.neg1");
    chk_rec(0, 1, 0, 0, 0, 0, "t2.neg256");
    chk_rec(0, 2, 255, 0, 1, 0, "t2.pos255");
    chk_rec(0, 3, 0, 1, 0, 0, "t2.zero");
    chk_rec(0, 5, 8, 0, 1, 1, "t2.last");

    // unexpected input while idle
    rec0.delete();
    drive(0, 0, 1, 9'd5);
    chk("t3.err_unexp", eu_s[0], 1);
    chk("t3.no_valid", ov_s[0], 0);
    tick();
    chk("t3.no_valid2", ov_s[0], 0);
    drive(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) drive(0, 0, 1, 9'(30 + k));
    wait_fd(0, "t3.frame_done");
    chk("t3.n_out", rec0.size(), 6);
    chk_rec(0, 0, 30, 1, 0, 0, "t3.o0");
    chk_rec(0, 5, 35, 0, 1, 1, "t3.o5");

    // backpressure and full FIFO on the 5x4 instance
    rec1.delete();
    rdy_s[1] = 0;
    drive(1, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 1, 9'(40 + k));
      if (k == 2) chk("t4.af_after3", af_s[1], 0);
      if (k == 3) chk("t4.af_after4", af_s[1], 1);
    end
    chk("t4.full_valid", ov_s[1], 1);
    chk("t4.full_no_ovf", eo_s[1], 0);
    rdy_s[1] = 1;
    drive(1, 0, 1, 9'd48);
    rdy_s[1] = 0;
    chk("t4.simul_no_ovf", eo_s[1], 0);
    chk("t4.simul_af", af_s[1], 1);
    chk("t4.simul_head", op_s[1], 41);
    drive(1, 0, 1, 9'd49);
    chk("t4.drop_ovf", eo_s[1], 1);
    chk("t4.head_stable", op_s[1], 41);
    rdy_s[1] = 1;
    for (int k = 0; k < 10; k++) tick();
    chk("t4.n_out", rec1.size(), 9);
    for (int k = 1; k < 9; k++) chk_rec(1, k, 8'(40 + k), (k == 5), (k == 4), 0, $sformatf("t4.o%0d", k));
    for (int k = 0; k < 10; k++) drive(1, 0, 1, 9'(50 + k));
    wait_fd(1, "t4.frame_done");
    chk("t4.n_total", rec1.size(), 19);
    chk_rec(1, 9, 50, 1, 0, 0, "t4.o50");
    chk_rec(1, 14, 55, 1, 0, 0, "t4.o55");
    chk_rec(1, 18, 59, 0, 1, 1, "t4.o59");

    // reset mid-frame with 3 entries buffered
    rdy_s[0] = 0;
    drive(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 9'(60 + k));
    chk("t5.buffered", ov_s[0], 1);
    reset = 1'b0;
    #1;
    chk("t5.rst_valid", ov_s[0], 0);
    chk("t5.rst_busy", busy_s[0], 0);
    chk("t5.rst_unexp", eu_s[0], 0);
    tick();
    reset = 1'b1;
    rdy_s[0] = 1;
    rec0.delete();
    tick();
    drive(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) drive(0, 0, 1, 9'(70 + k));
    wait_fd(0, "t5.frame_done");
    chk("t5.n_out", rec0.size(), 6);
    chk_rec(0, 0, 70, 1, 0, 0, "t5.o0");
    chk_rec(0, 2, 72, 0, 1, 0, "t5.o2");
    chk_rec(0, 3, 73, 1, 0, 0, "t5.o3");
    chk_rec(0, 5, 75, 0, 1, 1, "t5.o5");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/no_brdr_out_collector.md
Name: no_brdr_out_collector

Overview:
- Receives the no-border filter result stream (pix_valid / PIX_BIT+1-bit result) and clamps each result to PIX_BIT.
- Tags each pixel with line/frame position for the reduced output image, (ROW_WIDTH-MASK_WIDTH+1) x (COL_HEIGHT-MASK_WIDTH+1).
- Buffers results in a small FIFO and presents them downstream on a valid/ready handshake.
- Raises almost_full so the control unit can stop feeding pixels, since the filter pipeline itself cannot stall.

Parameters:
- ROW_WIDTH, 256, input pixels per row
- COL_HEIGHT, 256, input rows per frame
- PIX_BIT, 8, output pixel bits
- MASK_WIDTH, 3, mask width; output dims shrink by MASK_WIDTH-1
- FIFO_DEPTH, 8, FIFO entries (power of 2, >= SLACK+2)
- SLACK, 4, entries reserved for results still in the filter pipeline when almost_full rises

Ports:
- clk, input, 1: clock; all flops rising edge
- reset, input, 1: asynchronous, active-low reset
- start, input, 1: one-cycle pulse; arms collection of one frame
- pix_valid_in, input, 1: filter result valid
- pix_in, input, PIX_BIT+1: filter result, two's complement
- out_ready, input, 1: downstream accepts out_pix this cycle
- out_valid, output, 1: out_pix/tags valid
- out_pix, output, PIX_BIT: clamped pixel
- out_sol, output, 1: first pixel of output line
- out_eol, output, 1: last pixel of output line
- out_eof, output, 1: last pixel of frame
- almost_full, output, 1: FIFO count >= FIFO_DEPTH-SLACK
- busy, output, 1: state != IDLE
- frame_done, output, 1: one-cycle pulse after the eof pixel is popped
- err_ovf, output, 1: sticky; a push was dropped because the FIFO was full
- err_unexp, output, 1: sticky; pix_valid_in seen while IDLE or DRAIN

Behaviour:
- Reset (asynchronous, reset=0): FIFO empty, counters 0, state IDLE. Outputs out_valid=0, out_pix=0, out_sol/eol/eof=0, almost_full=0, busy=0, frame_done=0, err_ovf=0, err_unexp=0. Reset mid-frame discards all buffered data.
- Clamp (combinational before push):
  - pix_in MSB=1 (negative) -> 0.
  - Otherwise pix_in[PIX_BIT-1:0]; the non-negative range already fits PIX_BIT.
- FSM:
  - IDLE: start -> ACTIVE, col_cnt=0, row_cnt=0.
  - ACTIVE: each valid input is pushed with tags. After the push of the pixel at col=OW-1, row=OH-1 -> DRAIN.
  - DRAIN: no pushes. When the eof entry is popped -> IDLE with frame_done=1 for exactly that next cycle.
  - start outside IDLE is ignored.
- Counters (ACTIVE only), with OW=ROW_WIDTH-MASK_WIDTH+1 and OH=COL_HEIGHT-MASK_WIDTH+1:
  - col_cnt advances on every valid input and wraps at OW-1 to 0, incrementing row_cnt.
  - Tags: sol = (col==0); eol = (col==OW-1); eof = eol && (row==OH-1).
  - The counters advance even when the push is dropped for overflow, so framing stays aligned.
- pix_valid_in in IDLE/DRAIN: data dropped, err_unexp set.
- FIFO (first-word-fall-through):
  - Entry = {eof,eol,sol,pix}.
  - out_valid = !empty; outputs show the head entry.
  - Pop when out_valid && out_ready.
  - Push when ACTIVE && pix_valid_in && (!full || pop same cycle). Full plus simultaneous push and pop: both occur, count unchanged.
  - Push while full with no pop: dropped, err_ovf set.
  - Empty plus push: the data appears on out_valid the next cycle (1-cycle latency in to out).
  - Pointers wrap modulo FIFO_DEPTH; count is held in log2(FIFO_DEPTH)+1 bits.
- almost_full is registered from the count after each cycle's push/pop.
- Downstream may hold out_ready=0 indefinitely. Head data must stay stable while out_valid=1 && !out_ready.
- err_ovf/err_unexp clear only on reset.

Test Plan:
- Geometry ROW_WIDTH=5, COL_HEIGHT=4, MASK_WIDTH=3 (3x2 output); start, 6 back-to-back inputs 10..15, out_ready=1 -> 6 outputs 10..15:
  - sol on 1st and 4th, eol on 3rd and 6th, eof on 6th only.
  - frame_done pulses once, 1 cycle after the 6th pop; busy then falls.
- Clamp: inputs 9'h1FF, 9'h100, 9'h0FF, 9'h000 (PIX_BIT=8) -> 0, 0, 255, 0.
- Backpressure: out_ready=0, FIFO_DEPTH=8, SLACK=4, 9 inputs ->
  - almost_full=1 after the 4th push.
  - 9th input dropped; err_ovf=1.
  - 8 entries pop in order once out_ready=1.
- Full FIFO plus simultaneous push and pop -> no drop, err_ovf stays 0, count stays 8.
- pix_valid_in before start -> err_unexp=1, no out_valid; a following normal frame still completes correctly.
- reset asserted with 3 entries buffered mid-frame -> out_valid=0 immediately; after release, a new start and frame produce correct tags from sol.
